bufcap_ctrl: RTL
================

BUFCAP_CTRL -- requirements
Module: bufcap_ctrl

Interface
REQ-001 Parameter DW, default 8: sample and write-data width.
REQ-002 Parameter AW, default 8: buffer write-address width; buffer depth is 2^AW.
REQ-003 wclk  input  1  capture and write clock; the block SHALL use only this clock.
REQ-004 sreset  input  1  reset, asynchronous, active-high; clock wclk.
REQ-005 arm  input  1  single-cycle pulse that arms a capture.
REQ-006 abort  input  1  single-cycle pulse that cancels any activity.
REQ-007 trig  input  1  trigger qualifier, sampled only in ARMED.
REQ-008 len  input  AW  capture length in samples; 0 means 2^AW; sampled on arm.
REQ-009 din  input  DW  sample data.
REQ-010 din_valid  input  1  sample strobe.
REQ-011 wen  output  1  buffer write enable.
REQ-012 waddr  output  AW  buffer write address.
REQ-013 wdata  output  DW  buffer write data.
REQ-014 busy  output  1  high in ARMED or CAPTURE.
REQ-015 done  output  1  high in DONE.
REQ-016 count  output  AW+1  samples written in the current capture.

Function
REQ-017 The block SHALL implement four states: IDLE, ARMED, CAPTURE and DONE.
REQ-018 IDLE or DONE with arm=1 SHALL go to ARMED, latch len into len_r (0 becomes 2^AW), and clear count to 0.
REQ-019 ARMED with trig=1 SHALL go to CAPTURE; the trig cycle itself writes no sample.
REQ-020 In CAPTURE, each accepted din_valid SHALL produce, on the next wclk edge: wen=1, waddr=count[AW-1:0], wdata=din, and count incremented by 1.
REQ-021 Write latency SHALL be exactly 1 cycle from the accepted din_valid to wen; wen SHALL be 0 in every other cycle.
REQ-022 When the accepted sample makes count equal to len_r, the state SHALL be DONE on the same edge that asserts that sample's wen.
REQ-023 Accepting a sample while count equals len_r SHALL be impossible; the block SHALL never write more than len_r samples, and waddr SHALL never wrap within a capture.
REQ-024 arm SHALL be ignored in ARMED and CAPTURE.
REQ-025 abort=1 SHALL force IDLE on the next edge from any state, SHALL suppress any wen for that cycle, and SHALL take priority over arm, trig and din_valid.
REQ-026 count SHALL hold its value in DONE and IDLE until the next arm.
REQ-027 busy and done SHALL be decoded from registered state only, with no combinational path from inputs.

Reset
REQ-028 sreset=1 SHALL asynchronously force: state=IDLE, wen=0, waddr=0, wdata=0, count=0, len_r=0, busy=0, done=0.
REQ-029 A sreset mid-capture SHALL discard the capture; the first write after release SHALL occur only after a new arm and trig.

Configuration
REQ-030 Macro BUFCAP_CTRL_DECIM_EN SHALL be the only compile-time option.
REQ-031 With BUFCAP_CTRL_DECIM_EN defined: the block SHALL add input decim [7:0]; in CAPTURE it SHALL accept only every (decim+1)-th din_valid, starting with the first.
REQ-032 With the macro defined: the decimation counter SHALL clear on arm, abort and sreset, and decim SHALL be sampled on arm.
REQ-033 Without BUFCAP_CTRL_DECIM_EN: the decim port SHALL be absent and every din_valid in CAPTURE SHALL be accepted.

Verification
REQ-034 len=4, arm, trig, then din_valid held high with din=0xA0..0xA5 -> 4 writes, waddr 0..3, data 0xA0..0xA3; done=1 on the 4th wen edge; count=4.
REQ-035 len=0, AW=8, continuous din_valid -> 256 writes, waddr 0..255 with no wrap; count=256; done=1.
REQ-036 abort during CAPTURE after 2 writes -> wen=0 from the next edge; IDLE; count=2; no further writes.
REQ-037 arm pulsed in CAPTURE -> ignored; count, len_r and waddr sequence unchanged.
REQ-038 sreset asserted asynchronously mid-capture -> all outputs 0 immediately; no writes until a new arm and trig.
REQ-039 With BUFCAP_CTRL_DECIM_EN, decim=2, len=3, continuous din_valid with din=0..8 -> wdata 0, 3, 6; then done=1.

Source files
------------

// File: rtl/bufcap_ctrl.sv
// bufcap_ctrl: triggered capture controller that streams qualified samples into a write-only buffer.
// Ports:
//   wclk, sreset         clock and asynchronous active-high reset
//   arm, abort, trig     control pulses; arm latches len (and decim when enabled)
//   len [AW-1:0]         capture length in samples, 0 means 2^AW
//   din, din_valid       sample stream
//   wen, waddr, wdata    registered buffer write port, one cycle after an accepted sample
//   busy, done           state decodes (ARMED/CAPTURE, DONE)
//   count [AW:0]         samples written in the current capture
// Option: define BUFCAP_CTRL_DECIM_EN to add decim [7:0], keeping every (decim+1)-th sample.
module bufcap_ctrl #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          wclk,
  input  logic          sreset,
  input  logic          arm,
  input  logic          abort,
  input  logic          trig,
  input  logic [AW-1:0] len,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
`ifdef BUFCAP_CTRL_DECIM_EN
  input  logic [7:0]    decim,
`endif
  output logic          wen,
  output logic [AW-1:0] waddr,
  output logic [DW-1:0] wdata,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count
);
  typedef enum logic [1:0] {IDLE, ARMED, CAPTURE, DONE} state_t;
  state_t        state_q, state_d;
  logic [AW:0]   len_q, len_d, count_q, count_d, len_full;
  logic          wen_q, wen_d, dec_ok;
  logic [AW-1:0] waddr_q, waddr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  // A zero length request means the whole buffer.
  assign len_full = (len == '0) ? {1'b1, {AW{1'b0}}} : {1'b0, len};
`ifdef BUFCAP_CTRL_DECIM_EN
  logic [7:0] dcnt_q, dcnt_d, decim_q, decim_d;
  // Phase 0 of the decimation counter marks the sample to keep, so the first one is always taken.
  assign dec_ok = (dcnt_q == 8'd0);
  always_comb begin
    dcnt_d  = dcnt_q;
    decim_d = decim_q;
    if (abort) dcnt_d = '0;
    else if ((state_q == IDLE || state_q == DONE) && arm) begin
      dcnt_d  = '0;
      decim_d = decim;
    end else if (state_q == CAPTURE && din_valid) dcnt_d = (dcnt_q == decim_q) ? 8'd0 : dcnt_q + 8'd1;
  end
  always_ff @(posedge wclk or posedge sreset) begin
    if (sreset) begin
      dcnt_q  <= '0;
      decim_q <= '0;
    end else begin
      dcnt_q  <= dcnt_d;
      decim_q <= decim_d;
    end
  end
`else
  assign dec_ok = 1'b1;
`endif
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    wen_d   = 1'b0;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    if (abort) state_d = IDLE;
    else begin
      case (state_q)
        IDLE, DONE: if (arm) begin
          state_d = ARMED;
          len_d   = len_full;
          count_d = '0;
        end
        ARMED: if (trig) state_d = CAPTURE;
        CAPTURE: if (din_valid && dec_ok && count_q != len_q) begin
          // The count guard keeps a capture from ever writing past len_q or wrapping waddr.
          wen_d   = 1'b1;
          waddr_d = count_q[AW-1:0];
          wdata_d = din;
          count_d = count_q + 1'b1;
          state_d = (count_q + 1'b1 == len_q) ? DONE : CAPTURE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge wclk or posedge sreset) begin
    if (sreset) begin
      state_q <= IDLE;
      len_q   <= '0;
      count_q <= '0;
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      wen_q   <= wen_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end
  assign wen   = wen_q;
  assign waddr = waddr_q;
  assign wdata = wdata_q;
  assign count = count_q;
  assign busy  = (state_q == ARMED) || (state_q == CAPTURE);
  assign done  = (state_q == DONE);
endmodule
